dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU load/store path (after memory/IO address decode) and a debug/loader master, e.g. a UART program loader or a memory inspector.
- The CPU has normal priority. A starvation counter guarantees the debug master forward progress by stalling the CPU for one cycle when needed.
- A lock mode gives the debug master exclusive access for bulk loading.
- Sits between the memory/IO decode block and the data-memory block in the top level.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter_starve_counter.sv | 34 +++
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner/state encodings and
// default bus widths.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU path, the debug master, the data memory and the
// arbiter. The slave modport is the arbiter's view.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_ack;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              locked;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_ack, dbg_rvalid, dbg_rdata, locked,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_ack, dbg_rvalid, dbg_rdata, locked,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive denied debug-request cycles, saturating at LIMIT, so the
// arbiter can force a debug grant once the limit is reached.
module dmem_arbiter_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT_C) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign at_limit = (cnt == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: CPU has priority, the
// debug master gets a forced grant after STARVE_LIMIT denials or owns the port in LOCKED.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  owner_t            owner;
  logic              at_limit;
  logic              dbg_ack_c;
  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              rd_accept;

  logic              vld_p1;
  owner_t            tag_p1;

  dmem_arbiter_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .clr     (!bus.dbg_req || dbg_ack_c),
    .inc     (bus.dbg_req && !dbg_ack_c),
    .at_limit(at_limit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = bus.dbg_lock ? ST_LOCKED : ST_NORMAL;
    owner     = OWN_CPU;
    if (state_q == ST_LOCKED) begin
      owner = OWN_DBG;
    end else if (bus.dbg_req && (!bus.cpu_req || at_limit)) begin
      owner = OWN_DBG;
    end
    own_req   = bus.cpu_req;
    own_we    = bus.cpu_we;
    own_addr  = bus.cpu_addr;
    own_wdata = bus.cpu_wdata;
    if (owner == OWN_DBG) begin
      own_req   = bus.dbg_req;
      own_we    = bus.dbg_we;
      own_addr  = bus.dbg_addr;
      own_wdata = bus.dbg_wdata;
    end
    // Nothing may reach memory or be acknowledged while reset is held.
    dbg_ack_c = !reset && bus.dbg_req && (owner == OWN_DBG);
    rd_accept = !reset && own_req && !own_we;
  end

  assign bus.mem_we    = !reset && own_req && own_we;
  assign bus.mem_addr  = own_addr;
  assign bus.mem_wdata = own_wdata;
  assign bus.dbg_ack   = dbg_ack_c;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.cpu_stall = !reset &&
                         ((state_q == ST_LOCKED) || (bus.cpu_req && (owner == OWN_DBG)));

  // p1: memory read data returns; tag decides which master it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      tag_p1 <= OWN_CPU;
    end else begin
      vld_p1 <= rd_accept;
      tag_p1 <= owner;
    end
  end

  assign bus.dbg_rvalid = !reset && vld_p1 && (tag_p1 == OWN_DBG);
  assign bus.dbg_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model with its own memory image.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Data memory: registered read, cleared while reset is held.
  logic [DW-1:0] env_mem [0:255];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= '0;
    end else if (bus.mem_we) begin
      env_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= env_mem[bus.mem_addr[7:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_locked  = 1'b0;
  int            m_denied  = 0;
  bit            m_rd_pend = 1'b0;
  bit            m_rd_dbg  = 1'b0;
  logic [DW-1:0] m_rd_data = '0;
  logic [DW-1:0] ref_mem [0:255];

  bit            e_dbg_wins, e_ack, e_stall, e_we, e_rvalid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  task automatic model_eval();
    bit dw;
    if (m_locked) dw = 1'b1;
    else dw = bus.dbg_req && (!bus.cpu_req || (m_denied >= LIMIT));
    e_dbg_wins = dw;
    e_ack      = !reset && bus.dbg_req && dw;
    e_stall    = !reset && (m_locked || (bus.cpu_req && dw));
    e_we       = !reset && (dw ? (bus.dbg_req && bus.dbg_we) : (bus.cpu_req && bus.cpu_we));
    e_addr     = dw ? bus.dbg_addr : bus.cpu_addr;
    e_wdata    = dw ? bus.dbg_wdata : bus.cpu_wdata;
    e_rvalid   = !reset && m_rd_pend && m_rd_dbg;
  endtask

  task automatic model_commit();
    bit rd;
    if (reset) begin
      m_locked  = 1'b0;
      m_denied  = 0;
      m_rd_pend = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    end else begin
      rd = e_dbg_wins ? (bus.dbg_req && !bus.dbg_we) : (bus.cpu_req && !bus.cpu_we);
      if (rd) m_rd_data = ref_mem[e_addr[7:0]];
      m_rd_pend = rd;
      m_rd_dbg  = e_dbg_wins;
      if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
      if (bus.dbg_req && !e_ack) m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
      else m_denied = 0;
      m_locked = bus.dbg_lock;
    end
  endtask

  task automatic settle();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit lk);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d; bus.dbg_lock = lk;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cpu(1, 1, 14'h005, 32'h1111_1111);
    set_dbg(1, 1, 14'h006, 32'h2222_2222, 1);
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
      n_checks++; if (bus.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_ack: got %b want 0", bus.dbg_ack); end
      n_checks++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall: got %b want 0", bus.cpu_stall); end
      advance();
    end
    reset = 1'b0;
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
    settle();
    n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.dbg_rvalid); end
    advance();
  endtask

  task automatic test_cpu_only();
    set_cpu(1, 1, 14'h010, 32'hDEAD_BEEF);
    settle();
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 14'h010) begin n_fail++; $display("FAIL cpu_wr_addr: got %h want 010", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_wr_data: got %h want deadbeef", bus.mem_wdata); end
    n_checks++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_stall: got %b want 0", bus.cpu_stall); end
    advance();
    set_cpu(1, 0, 14'h010, '0);
    settle();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_we: got %b want 0", bus.mem_we); end
    n_checks++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_stall: got %b want 0", bus.cpu_stall); end
    advance();
    set_cpu(0, 0, '0, '0);
    settle();
    n_checks++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_rdata: got %h want deadbeef", bus.cpu_rdata); end
    n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_no_dbg_rvalid: got %b want 0", bus.dbg_rvalid); end
    advance();
  endtask

  task automatic test_dbg_only();
    set_dbg(1, 1, 14'h020, 32'h1234_5678, 0);
    settle();
    n_checks++; if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_ack: got %b want 1", bus.dbg_ack); end
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_we: got %b want 1", bus.mem_we); end
    advance();
    set_dbg(0, 0, '0, '0, 0);
    settle();
    n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg_wr_no_rvalid: got %b want 0", bus.dbg_rvalid); end
    advance();
    set_dbg(1, 0, 14'h020, '0, 0);
    settle();
    n_checks++; if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_rd_ack: got %b want 1", bus.dbg_ack); end
    advance();
    set_dbg(0, 0, '0, '0, 0);
    settle();
    n_checks++; if (bus.dbg_rvalid !== 1'b1) begin n_fail++; $display("FAIL dbg_rvalid: got %b want 1", bus.dbg_rvalid); end
    n_checks++; if (bus.dbg_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dbg_rdata: got %h want 12345678", bus.dbg_rdata); end
    advance();
    settle();
    n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg_rvalid_one_cycle: got %b want 0", bus.dbg_rvalid); end
    advance();
  endtask

  task automatic test_contention();
    bit want;
    set_cpu(1, 0, 14'h030, '0);
    set_dbg(1, 0, 14'h020, '0, 0);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      want = (cyc % 5 == 0);
      settle();
      n_checks++; if (bus.dbg_ack !== want) begin n_fail++; $display("FAIL contention_ack c%0d: got %b want %b", cyc, bus.dbg_ack, want); end
      n_checks++; if (bus.cpu_stall !== want) begin n_fail++; $display("FAIL contention_stall c%0d: got %b want %b", cyc, bus.cpu_stall, want); end
      advance();
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
  endtask

  task automatic test_idle_gap();
    set_cpu(1, 0, 14'h031, '0);
    for (int cyc = 0; cyc < 16; cyc++) begin
      set_dbg((cyc % 4) != 3, 0, 14'h021, '0, 0);
      settle();
      n_checks++; if (bus.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL idle_gap_ack c%0d: got %b want 0", cyc, bus.dbg_ack); end
      n_checks++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL idle_gap_stall c%0d: got %b want 0", cyc, bus.cpu_stall); end
      advance();
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
  endtask

  task automatic test_lock();
    logic [AW-1:0] a;
    set_cpu(1, 1, 14'h080, 32'h0000_CAFE);
    set_dbg(1, 1, 14'h000, 32'hA5A5_0000, 1);
    settle();
    n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_first_locked: got %b want 0", bus.locked); end
    n_checks++; if (bus.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL lock_first_ack: got %b want 0", bus.dbg_ack); end
    advance();
    for (int i = 0; i < 8; i++) begin
      a = AW'(i);
      set_dbg(1, 1, a, 32'hA5A5_0000 + DW'(i), 1);
      settle();
      n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_wr_locked %0d: got %b want 1", i, bus.locked); end
      n_checks++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lock_wr_stall %0d: got %b want 1", i, bus.cpu_stall); end
      n_checks++; if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL lock_wr_ack %0d: got %b want 1", i, bus.dbg_ack); end
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== a) begin n_fail++; $display("FAIL lock_wr_port %0d: got we=%b addr=%h want we=1 addr=%h", i, bus.mem_we, bus.mem_addr, a); end
      advance();
    end
    for (int i = 0; i <= 8; i++) begin
      a = AW'(i);
      if (i < 8) set_dbg(1, 0, a, '0, 1);
      else set_dbg(0, 0, '0, '0, 1);
      settle();
      n_checks++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lock_rd_stall %0d: got %b want 1", i, bus.cpu_stall); end
      if (i < 8) begin
        n_checks++; if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL lock_rd_ack %0d: got %b want 1", i, bus.dbg_ack); end
      end
      if (i > 0) begin
        n_checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hA5A5_0000 + DW'(i - 1)) begin
          n_fail++; $display("FAIL lock_readback %0d: got v=%b d=%h want v=1 d=%h", i - 1, bus.dbg_rvalid, bus.dbg_rdata, 32'hA5A5_0000 + DW'(i - 1));
        end
      end
      advance();
    end
    set_dbg(0, 0, '0, '0, 0);
    settle();
    n_checks++; if (bus.locked !== 1'b1 || bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL unlock_edge: got locked=%b stall=%b want 1 1", bus.locked, bus.cpu_stall); end
    advance();
    settle();
    n_checks++; if (bus.locked !== 1'b0 || bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL unlocked: got locked=%b stall=%b want 0 0", bus.locked, bus.cpu_stall); end
    advance();
    set_cpu(0, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    bit want;
    set_cpu(0, 0, '0, '0);
    set_dbg(1, 0, 14'h020, '0, 0);
    settle();
    n_checks++; if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %b want 1", bus.dbg_ack); end
    advance();
    reset = 1'b1;
    set_cpu(1, 0, 14'h033, '0);
    set_dbg(1, 0, 14'h022, '0, 1);
    settle();
    n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid_in_reset: got %b want 0", bus.dbg_rvalid); end
    advance();
    reset = 1'b0;
    set_dbg(1, 0, 14'h022, '0, 0);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      want = (cyc == 5);
      settle();
      if (cyc == 1) begin
        n_checks++; if (bus.dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid_after: got %b want 0", bus.dbg_rvalid); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL rstmid_locked: got %b want 0", bus.locked); end
      end
      n_checks++; if (bus.dbg_ack !== want) begin n_fail++; $display("FAIL rstmid_starve c%0d: got %b want %b", cyc, bus.dbg_ack, want); end
      advance();
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
  endtask

  task automatic test_random();
    bit lk = 1'b0;
    reset = 1'b1;
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
    settle();
    advance();
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) lk = !lk;
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 255)), DW'($urandom));
      if (!bus.dbg_req || e_ack)
        set_dbg($urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 255)), DW'($urandom), lk);
      else
        bus.dbg_lock = lk;
      settle();
      n_checks++; if (bus.dbg_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b want %b", cyc, bus.dbg_ack, e_ack); end
      n_checks++; if (bus.cpu_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, bus.cpu_stall, e_stall); end
      n_checks++; if (bus.mem_we !== e_we) begin n_fail++; $display("FAIL rnd_mem_we c%0d: got %b want %b", cyc, bus.mem_we, e_we); end
      n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL rnd_locked c%0d: got %b want %b", cyc, bus.locked, m_locked); end
      n_checks++; if (bus.dbg_rvalid !== e_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, bus.dbg_rvalid, e_rvalid); end
      if (e_we) begin
        n_checks++; if (bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin
          n_fail++; $display("FAIL rnd_wr_port c%0d: got %h/%h want %h/%h", cyc, bus.mem_addr, bus.mem_wdata, e_addr, e_wdata);
        end
      end
      if (e_rvalid) begin
        n_checks++; if (bus.dbg_rdata !== m_rd_data) begin n_fail++; $display("FAIL rnd_dbg_rdata c%0d: got %h want %h", cyc, bus.dbg_rdata, m_rd_data); end
      end
      if (m_rd_pend && !m_rd_dbg) begin
        n_checks++; if (bus.cpu_rdata !== m_rd_data) begin n_fail++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", cyc, bus.cpu_rdata, m_rd_data); end
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0, 0);
    test_reset();
    test_cpu_only();
    test_dbg_only();
    test_contention();
    test_idle_gap();
    test_lock();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
